// File: rtl/score_ram_init_writer_pkg.sv
// Shared parameters and FSM encoding for the score-matrix boundary writer.
package score_ram_init_writer_pkg;

    localparam int N_DEF      = 8;
    localparam int GAP_DEF    = 2;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_COL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/score_ram_init_writer_if.sv
// Score RAM write port plus init control/status, seen from the writer (master)
// and from the controller/RAM side (slave).
interface score_ram_init_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic                     en_init;
    logic                     we;
    logic [ADDR_W-1:0]        addr;
    logic signed [DATA_W-1:0] data;
    logic                     busy;
    logic                     hit;

    modport master (input en_init, output we, addr, data, busy, hit);
    modport slave  (output en_init, input we, addr, data, busy, hit);
endinterface

// File: rtl/score_ram_init_writer_index_counter.sv
// Row/column step counter; clr restarts the count and may coincide with en
// (clr+en lands on 1, which is the first column index).
module init_index_counter #(
    parameter int N      = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = (clr ? '0 : idx_q) + ADDR_W'(en);
    end

    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    assign idx  = idx_q;
    assign last = (idx_q == ADDR_W'(N));

endmodule

// File: rtl/score_ram_init_writer.sv
// Writes row 0 and column 0 of the (N+1)x(N+1) score matrix before fill.
// Optional SCORE_INIT_LOCAL_EN: Smith-Waterman style, all boundary scores are 0.
module score_ram_init_writer
    import score_ram_init_writer_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int GAP    = GAP_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic                     clk,
    input logic                     rst,
    score_ram_init_writer_if.master bus
);

`ifdef SCORE_INIT_LOCAL_EN
    localparam int STEP = 0;
`else
    localparam int STEP = GAP;
`endif

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic                     busy_q, busy_d;
    logic                     hit_q, hit_d;
    logic                     cnt_en, cnt_clr;
    logic [ADDR_W-1:0]        idx;
    logic                     last;

    init_index_counter #(.N(N), .ADDR_W(ADDR_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .idx  (idx),
        .last (last)
    );

    // Outputs are registered: each advancing edge issues the next write, so
    // the cell on the bus is the one idx/acc currently describe.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        hit_d   = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            S_IDLE: if (bus.en_init) begin
                state_d = S_ROW;
                we_d    = 1'b1;
                addr_d  = '0;
                acc_d   = '0;
                busy_d  = 1'b1;
                cnt_clr = 1'b1;
            end
            S_ROW: if (bus.en_init) begin
                we_d   = 1'b1;
                cnt_en = 1'b1;
                if (last) begin
                    // (0,0) already written: column starts at i=1 with -GAP
                    state_d = S_COL;
                    cnt_clr = 1'b1;
                    addr_d  = ADDR_W'(N + 1);
                    acc_d   = -DATA_W'(STEP);
                end else begin
                    addr_d = idx + ADDR_W'(1);
                    acc_d  = acc_q - DATA_W'(STEP);
                end
            end
            S_COL: if (bus.en_init) begin
                if (last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    hit_d   = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    cnt_en = 1'b1;
                    addr_d = addr_q + ADDR_W'(N + 1);
                    acc_d  = acc_q - DATA_W'(STEP);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        data_d = acc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.we   = we_q;
    assign bus.addr = addr_q;
    assign bus.data = data_q;
    assign bus.busy = busy_q;
    assign bus.hit  = hit_q;

endmodule

// File: tb/tb_score_ram_init_writer.sv
// Directed bench for score_ram_init_writer at N=4, GAP=2: reset, full run,
// stall, back-to-back restart, mid-run reset, write-once scoreboard.
module tb_score_ram_init_writer;

    localparam int N      = 4;
    localparam int GAP    = 2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam int NWR    = 2 * N + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    score_ram_init_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    score_ram_init_writer #(.N(N), .GAP(GAP), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int k);
        return (k <= N) ? k : (k - N) * (N + 1);
    endfunction

    function automatic int exp_data(input int k);
`ifdef SCORE_INIT_LOCAL_EN
        return 0;
`else
        return (k <= N) ? -(k * GAP) : -((k - N) * GAP);
`endif
    endfunction

    function automatic bit is_boundary(input int a);
        return (a <= N) || ((a % (N + 1) == 0) && (a / (N + 1) <= N));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // en_init is already set for the starting edge; first write expected
    // first_lat cycles later. Stall drops en_init after the write to stall_at.
    task automatic do_run(input int stall_at, input int stall_len,
                          input int first_lat, input string tag);
        int cnt[128];
        int k = 0, c = 0, hit_c = -1, last_wr = -1, first_wr = -1;
        int busy_cnt = 0, stall_rem = 0, outside = 0;
        int held_addr = 0, held_data = 0;
        foreach (cnt[a]) cnt[a] = 0;
        while (c < 200 && hit_c < 0) begin
            cyc();
            c++;
            if (bus_if.busy) busy_cnt++;
            if (bus_if.we) begin
                if (first_wr < 0) first_wr = c;
                chk($sformatf("%s_addr%0d", tag, k), int'(bus_if.addr), exp_addr(k));
                chk($sformatf("%s_data%0d", tag, k), int'($signed(bus_if.data)), exp_data(k));
                chk($sformatf("%s_nohit%0d", tag, k), int'(bus_if.hit), 0);
                cnt[bus_if.addr]++;
                last_wr   = c;
                held_addr = int'(bus_if.addr);
                held_data = int'($signed(bus_if.data));
                k++;
                if (stall_len > 0 && int'(bus_if.addr) == stall_at) begin
                    bus_if.en_init = 1'b0;
                    stall_rem = stall_len;
                end
            end else if (stall_rem > 0) begin
                chk($sformatf("%s_stall_addr%0d", tag, stall_rem), int'(bus_if.addr), held_addr);
                chk($sformatf("%s_stall_data%0d", tag, stall_rem), int'($signed(bus_if.data)), held_data);
                chk($sformatf("%s_stall_busy%0d", tag, stall_rem), int'(bus_if.busy), 1);
                stall_rem--;
                if (stall_rem == 0) bus_if.en_init = 1'b1;
            end
            if (bus_if.hit) hit_c = c;
        end
        chk({tag, "_hit_seen"}, int'(hit_c >= 0), 1);
        chk({tag, "_first_lat"}, first_wr, first_lat);
        chk({tag, "_writes"}, k, NWR);
        chk({tag, "_hit_lat"}, hit_c - last_wr, 1);
        chk({tag, "_busy_span"}, busy_cnt, NWR + stall_len);
        for (int a = 0; a < 128; a++) begin
            if (is_boundary(a)) chk($sformatf("%s_sb%0d", tag, a), cnt[a], 1);
            else outside += cnt[a];
        end
        chk({tag, "_sb_outside"}, outside, 0);
    endtask

    initial begin
        int found;
        bus_if.en_init = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("rst_we",   int'(bus_if.we),   0);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_hit",  int'(bus_if.hit),  0);
        chk("rst_addr", int'(bus_if.addr), 0);
        chk("rst_data", int'($signed(bus_if.data)), 0);

        rst = 1'b0;
        cyc();
        cyc();
        chk("idle_we", int'(bus_if.we), 0);

        // full run, en_init held
        bus_if.en_init = 1'b1;
        do_run(-1, 0, 1, "run");
        bus_if.en_init = 1'b0;
        cyc();
        chk("post_hit_pulse", int'(bus_if.hit), 0);
        chk("post_we", int'(bus_if.we), 0);
        cyc();
        chk("post_idle_we", int'(bus_if.we), 0);

        // stall after addr=2; en_init stays high at the end for a back-to-back run
        bus_if.en_init = 1'b1;
        do_run(2, 3, 1, "stl");
        do_run(-1, 0, 2, "b2b");
        bus_if.en_init = 1'b0;
        cyc();
        cyc();

        // reset during the addr=10 write
        bus_if.en_init = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            cyc();
            if (bus_if.we && int'(bus_if.addr) == 10) found = 1;
        end
        chk("mr_found_addr10", found, 1);
        rst = 1'b1;
        cyc();
        chk("mr_we",   int'(bus_if.we),   0);
        chk("mr_busy", int'(bus_if.busy), 0);
        chk("mr_hit",  int'(bus_if.hit),  0);
        rst = 1'b0;
        do_run(-1, 0, 1, "mr2");
        bus_if.en_init = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
